// File: rtl/post_card_pkg.sv
// rtl/post_card_pkg.sv - shared types and defaults for the POST code display sequencer
// Purpose: FSM state encoding, default parameter values and the POST port address.
// Ports: none (package).
package post_card_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LIVE    = 2'd1,
        ST_HISTORY = 2'd2
    } state_t;

    localparam int DEF_DEPTH           = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;

    localparam logic [19:0] POST_PORT_ADDR = 20'h80;

endpackage

// File: rtl/post_sync_debounce.sv
// rtl/post_sync_debounce.sv - push-button synchronizer, debouncer and press detector
// Purpose: brings a raw bouncing button into the clock domain and emits one pulse per push.
// Ports:
//   clk_i    in   system clock
//   rst_i    in   asynchronous active-high reset
//   btn_i    in   raw button level, active-high
//   press_o  out  one-cycle pulse when the debounced level goes 0->1
module post_sync_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q;

    // The counter tracks consecutive samples that disagree with the accepted
    // level; any agreeing sample restarts it, so bounces never accumulate.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/post_display_sequencer.sv
// rtl/post_display_sequencer.sv - POST code history buffer and two-digit display selector
// Purpose: records port-80h codes in a circular buffer and picks the live or a browsed code for display.
// Ports:
//   clk_i            in   system clock
//   rst_i            in   asynchronous active-high reset
//   code_strobe_i    in   raw strobe, rising edge = new code latched
//   code_data_i      in   latched POST code
//   button_i         in   raw push button, active-high
//   display_data_o   out  byte for the BCD decoder
//   display_valid_o  out  buffer holds at least one code
//   history_mode_o   out  browsing history
//   history_index_o  out  age of the shown entry, 0 = newest
//   new_code_flag_o  out  a code arrived while browsing
module post_display_sequencer
    import post_card_pkg::*;
#(
    parameter int DEPTH           = DEF_DEPTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     code_strobe_i,
    input  logic [7:0]               code_data_i,
    input  logic                     button_i,
    output logic [7:0]               display_data_o,
    output logic                     display_valid_o,
    output logic                     history_mode_o,
    output logic [$clog2(DEPTH)-1:0] history_index_o,
    output logic                     new_code_flag_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       strb_q;
    logic             wr_en, press;
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, view_q;
    logic [CNT_W-1:0] count_q;
    logic [TMR_W-1:0] timer_q;
    logic             flag_q;

    logic [PTR_W-1:0] newest, age_q, view_step, view_sel, enter_view;
    logic [CNT_W-1:0] age_next;

    logic [7:0]       display_d, display_q;
    logic             valid_d, valid_q, mode_d, mode_q;
    logic [PTR_W-1:0] index_d, index_q;

    // Two sync stages plus a history bit: the write pulse is high between the
    // 2nd and 3rd edges after the raw rise, so the write lands on the 3rd.
    assign wr_en = strb_q[1] & ~strb_q[2];

    post_sync_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_button (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (button_i),
        .press_o (press)
    );

    // All decisions use pre-write pointers; a simultaneous write is applied afterwards.
    assign newest     = wr_ptr_q - PTR_ONE;
    assign age_q      = newest - view_q;
    assign age_next   = {1'b0, age_q} + CNT_ONE;
    assign view_step  = view_q - PTR_ONE;
    assign view_sel   = press ? view_step : view_q;
    assign enter_view = wr_ptr_q - PTR_TWO;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_en) state_d = ST_LIVE;
            end
            ST_LIVE: begin
                if (press && count_q >= CNT_TWO && !(wr_en && wr_ptr_q == enter_view)) begin
                    state_d = ST_HISTORY;
                end
            end
            ST_HISTORY: begin
                if (press && age_next == count_q) begin
                    state_d = ST_LIVE;
                end else if (!press && timer_q == TMR_LAST) begin
                    state_d = ST_LIVE;
                end else if (wr_en && wr_ptr_q == view_sel) begin
                    // The incoming code would overwrite the entry on display.
                    state_d = ST_LIVE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        display_d = 8'h00;
        valid_d   = (count_q != '0);
        mode_d    = 1'b0;
        index_d   = '0;
        case (state_q)
            ST_LIVE: begin
                display_d = mem_q[newest];
            end
            ST_HISTORY: begin
                display_d = mem_q[view_q];
                mode_d    = 1'b1;
                index_d   = age_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strb_q   <= '0;
            wr_ptr_q <= '0;
            view_q   <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            flag_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            strb_q <= {strb_q[1:0], code_strobe_i};
            if (wr_en) begin
                mem_q[wr_ptr_q] <= code_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
                if (count_q != CNT_FULL) count_q <= count_q + CNT_ONE;
            end
            if (state_q == ST_LIVE && state_d == ST_HISTORY) begin
                view_q <= enter_view;
            end else if (state_q == ST_HISTORY && press) begin
                view_q <= view_step;
            end
            if (state_q == ST_HISTORY && state_d == ST_HISTORY && !press) begin
                timer_q <= timer_q + TMR_ONE;
            end else begin
                timer_q <= '0;
            end
            if (state_d == ST_LIVE && state_q != ST_LIVE) begin
                flag_q <= 1'b0;
            end else if (wr_en && state_q == ST_HISTORY) begin
                flag_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            display_q <= 8'h00;
            valid_q   <= 1'b0;
            mode_q    <= 1'b0;
            index_q   <= '0;
        end else begin
            display_q <= display_d;
            valid_q   <= valid_d;
            mode_q    <= mode_d;
            index_q   <= index_d;
        end
    end

    assign display_data_o  = display_q;
    assign display_valid_o = valid_q;
    assign history_mode_o  = mode_q;
    assign history_index_o = index_q;
    assign new_code_flag_o = flag_q;

endmodule

// File: tb/tb_post_display_sequencer.sv
// tb/tb_post_display_sequencer.sv - self-checking bench for post_display_sequencer
module tb_post_display_sequencer;

    localparam int DEPTH   = 8;
    localparam int DEB     = 16;
    localparam int TIMEOUT = 1024;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       code_strobe_i = 1'b0;
    logic [7:0] code_data_i = 8'h00;
    logic       button_i = 1'b0;
    logic [7:0] display_data_o;
    logic       display_valid_o;
    logic       history_mode_o;
    logic [2:0] history_index_o;
    logic       new_code_flag_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the full list of codes ever written, plus the absolute
    // index of the browsed code in that list.
    logic [7:0] codes[$];
    bit         m_hist;
    int         m_view;
    bit         m_flag;
    int         hist_cycles;

    post_display_sequencer #(
        .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .code_strobe_i(code_strobe_i),
        .code_data_i(code_data_i), .button_i(button_i),
        .display_data_o(display_data_o), .display_valid_o(display_valid_o),
        .history_mode_o(history_mode_o), .history_index_o(history_index_o),
        .new_code_flag_o(new_code_flag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int stored();
        return (codes.size() < DEPTH) ? codes.size() : DEPTH;
    endfunction

    task automatic m_reset();
        codes.delete();
        m_hist = 0; m_view = 0; m_flag = 0; hist_cycles = 0;
    endtask

    task automatic m_write(input logic [7:0] c);
        int n = codes.size();
        if (m_hist) begin
            if (n - m_view == DEPTH) begin
                m_hist = 0; m_flag = 0;
            end else begin
                m_flag = 1;
            end
        end
        codes.push_back(c);
    endtask

    task automatic m_press();
        int n = codes.size();
        if (n == 0) return;
        if (!m_hist) begin
            if (stored() >= 2) begin
                m_hist = 1; m_view = n - 2; m_flag = 0;
            end
        end else if ((n - 1 - m_view) + 1 == stored()) begin
            m_hist = 0; m_flag = 0;
        end else begin
            m_view--;
        end
    endtask

    task automatic m_timeout();
        if (m_hist) begin
            m_hist = 0; m_flag = 0;
        end
    endtask

    task automatic check_model(input string tag);
        int n = codes.size();
        logic [7:0] e_data;
        logic [2:0] e_idx;
        e_data = 8'h00;
        e_idx  = 3'd0;
        if (n > 0) e_data = m_hist ? codes[m_view] : codes[n-1];
        if (m_hist) e_idx = 3'(n - 1 - m_view);
        chk({tag, "_data"},  display_data_o,  e_data);
        chk({tag, "_valid"}, display_valid_o, n > 0);
        chk({tag, "_mode"},  history_mode_o,  m_hist);
        chk({tag, "_index"}, history_index_o, e_idx);
        chk({tag, "_flag"},  new_code_flag_o, m_flag);
    endtask

    task automatic strobe_code(input logic [7:0] c);
        @(negedge clk_i);
        code_data_i = c;
        code_strobe_i = 1'b1;
        repeat (4) @(negedge clk_i);
        code_strobe_i = 1'b0;
        repeat (6) @(negedge clk_i);
        m_write(c);
        if (m_hist) hist_cycles += 10;
    endtask

    task automatic press_btn();
        @(negedge clk_i);
        button_i = 1'b1;
        repeat (DEB + 10) @(negedge clk_i);
        button_i = 1'b0;
        repeat (DEB + 10) @(negedge clk_i);
        m_press();
        hist_cycles = 52;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        m_reset();
        check_model("reset");
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        m_reset();
        // T1: reset state, then two codes with exact display latency on the second
        repeat (3) @(negedge clk_i);
        check_model("t1_rst");
        rst_i = 1'b0;
        strobe_code(8'h11);
        check_model("t1_first");
        @(negedge clk_i);
        code_data_i = 8'h22;
        code_strobe_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 chk("t1_lat3", display_data_o, 8'h11);
        @(posedge clk_i);
        #1 chk("t1_lat4", display_data_o, 8'h22);
        @(negedge clk_i);
        code_strobe_i = 1'b0;
        repeat (6) @(negedge clk_i);
        m_write(8'h22);
        check_model("t1");

        // T2: browse back through 33,22,11 and wrap to live
        strobe_code(8'h33);
        press_btn();
        chk("t2_p1_data", display_data_o, 8'h22);
        chk("t2_p1_idx", history_index_o, 3'd1);
        check_model("t2_p1");
        press_btn();
        chk("t2_p2_data", display_data_o, 8'h11);
        check_model("t2_p2");
        press_btn();
        chk("t2_p3_mode", history_mode_o, 1'b0);
        chk("t2_p3_data", display_data_o, 8'h33);
        check_model("t2_p3");

        // T3: bouncy press gives one step; short pulse gives none
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            button_i = ~button_i;
            repeat (2) @(negedge clk_i);
        end
        repeat (DEB + 10) @(negedge clk_i);
        button_i = 1'b0;
        repeat (DEB + 10) @(negedge clk_i);
        m_press();
        check_model("t3_bounce");
        button_i = 1'b1;
        repeat (DEB - 6) @(negedge clk_i);
        button_i = 1'b0;
        repeat (30) @(negedge clk_i);
        check_model("t3_short");

        // T4: arrival mid-browse, then timeout back to live
        strobe_code(8'h44);
        chk("t4_data", display_data_o, 8'h22);
        chk("t4_idx", history_index_o, 3'd2);
        chk("t4_flag", new_code_flag_o, 1'b1);
        check_model("t4_arrive");
        repeat (850) @(negedge clk_i);
        check_model("t4_before_to");
        repeat (250) @(negedge clk_i);
        m_timeout();
        chk("t4_to_data", display_data_o, 8'h44);
        check_model("t4_after_to");

        // T5: full buffer, view oldest, a new code forces live
        do_reset();
        for (int i = 1; i <= DEPTH; i++) strobe_code(8'(i));
        for (int i = 0; i < DEPTH - 1; i++) press_btn();
        chk("t5_oldest", display_data_o, 8'h01);
        check_model("t5_oldest");
        strobe_code(8'h09);
        chk("t5_forced_mode", history_mode_o, 1'b0);
        chk("t5_forced_data", display_data_o, 8'h09);
        check_model("t5_forced");
        for (int i = 0; i < DEPTH; i++) begin
            press_btn();
            check_model("t5_walk");
        end
        chk("t5_count_sat", history_mode_o, 1'b0);

        // T6: reset mid-browse, presses ignored until a code arrives
        press_btn();
        check_model("t6_browse");
        do_reset();
        press_btn();
        check_model("t6_ignored");
        strobe_code(8'h5a);
        press_btn();
        check_model("t6_one_code");

        // Randomized operation mix against the model
        hist_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (m_hist && hist_cycles > 600) begin
                repeat (TIMEOUT + 64) @(negedge clk_i);
                m_timeout();
                hist_cycles = 0;
                check_model("rnd_timeout");
            end
            if ($urandom_range(0, 9) < 5) strobe_code(8'($urandom));
            else press_btn();
            check_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
